uart_pkt_tx: RTL
================

Name: uart_pkt_tx

Overview:
- Parametrised multi-byte UART packet transmitter. It serialises a packet of NUM_BYTES words, each DATA_BITS wide, onto the TX line as back-to-back UART frames.
- Each frame is: one start bit, DATA_BITS data bits LSB-first, an optional parity bit, and STOP_BITS stop bits.
- Sits between the response FIFO / register-access engine and the board TX pin. The baud-rate generator supplies a shared baud_tick.
- Uses a valid/ready handshake instead of a FIFO read strobe.

Parameters:
- DATA_BITS, 8: data bits per frame (5..9).
- NUM_BYTES, 3: frames per packet (1..16).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_tick  in  1  one-clk pulse per bit period.
- pkt_valid  in  1  packet available on pkt_data.
- pkt_data  in  NUM_BYTES*DATA_BITS  packet payload; word 0 = bits [DATA_BITS-1:0] and is sent first.
- pkt_ready  out  1  block can accept a packet this cycle.
- pkt_done  out  1  one-clk pulse when the last stop bit of the packet completes.
- tx_busy  out  1  high from packet acceptance until pkt_done.
- tx  out  1  serial line; idle high.

Behaviour:
- Reset values: tx=1, pkt_ready=0 during reset then 1 in the first idle cycle, pkt_done=0, tx_busy=0. State=IDLE; counters and shift register cleared.
- Reset mid-packet: tx returns to 1 asynchronously and the partial packet is discarded. No pkt_done is issued.
- pkt_ready=1 only in IDLE (combinational from state). Acceptance = pkt_valid && pkt_ready.
- On the acceptance edge, pkt_data is latched into the shift register, byte_idx=0, tx_busy=1, and the state goes to START. pkt_data is ignored thereafter.
- All tx updates and state transitions other than the acceptance itself occur only on clk edges with baud_tick=1. tx is registered and holds its value for exactly one tick interval.
- States and transitions:
  - IDLE: tx=1. Acceptance -> START.
  - START: on a tick, tx<=0, bit_cnt=0 -> DATA.
  - DATA: on a tick, tx<=shift[0] and the shift register shifts right by 1. After DATA_BITS bits -> PARITY if enabled, else STOP.
  - PARITY: on a tick, tx<=parity of the current word -> STOP.
  - STOP: on a tick, tx<=1. After STOP_BITS ticks, the next tick ends the frame.
- End of frame:
  - If byte_idx<NUM_BYTES-1: byte_idx++, and tx<=0 (start bit of the next frame) on that same tick, so there is no idle gap between frames.
  - Otherwise: state goes to IDLE, pkt_done=1 for that cycle, tx_busy<=0. pkt_ready=1 from the next cycle.
- Acceptance coinciding with baud_tick: the latch happens on that edge. The start bit is driven on the following tick, so start latency is 1..2 tick periods after acceptance.
- Frame length in ticks = 1 + DATA_BITS + P + STOP_BITS, where P=1 when parity is enabled, else 0.
- Packet duration from the first start bit to pkt_done = NUM_BYTES × frame length.
- A baud_tick arriving in IDLE has no effect. pkt_valid held while busy is not consumed.
- Counter widths: bit_cnt = $clog2(DATA_BITS+1); byte_idx = $clog2(NUM_BYTES+1).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. The parity bit is even or odd per PARITY_ODD, computed over the DATA_BITS of the current word before shifting begins.
- Undefined: no PARITY state and no parity logic. Frame = start + data + stop. PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg:
  - tx_state_e (IDLE, START, DATA, PARITY, STOP), typedef logic [3:0].
  - UART_IDLE_LEVEL = 1'b1.
  - Function frame_len(DATA_BITS, STOP_BITS, parity_en).
- Sub-module uart_tx_frame: single-frame serialiser with word, valid, and tick in; tx and frame_done out.
- uart_pkt_tx holds the packet register, byte sequencing, and the handshake.

Test Plan:
- Defaults, baud_tick every 4 clk, pkt_data=24'hA5_10_3C accepted -> tx shows the frames 0,0011_1100 (LSB-first),1 then 0x10 then 0xA5. Total 30 ticks. pkt_done is a single pulse on the 30th tick after the first start bit, and tx_busy falls on the same edge.
- Back-to-back packets with pkt_valid held high -> the second packet is accepted the cycle after pkt_done. At least one idle-high tick precedes the second start bit. pkt_ready=0 throughout the first packet.
- pkt_valid asserted in the same cycle as baud_tick -> start bit appears on the next tick, not the current one. pkt_data changed mid-packet does not alter the transmitted bits.
- Assert rst during the 2nd frame's DATA state -> tx=1 immediately (asynchronous), no pkt_done. After release, a new packet 24'h000001 transmits correctly.
- DATA_BITS=7, NUM_BYTES=1, STOP_BITS=2, UART_TX_PARITY_EN defined, PARITY_ODD=1, word 7'h55 -> bits 0,1010101,1(odd parity over four 1s),1,1. Frame = 11 ticks.
- UART_TX_PARITY_EN undefined, NUM_BYTES=16 -> 160 ticks per packet, byte_idx wraps correctly, and the last word (bits [127:120]) is sent last.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART packet TX block   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA   = 4'd2,
    PARITY = 4'd3,
    STOP   = 4'd4
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int frame_len(input int data_bits, input int stop_bits, input bit parity_en);
    return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pkt_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkt_tx_if : packet valid/ready handshake and status bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_pkt_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BYTES = 3
);
  logic                           pkt_valid;
  logic [NUM_BYTES*DATA_BITS-1:0] pkt_data;
  logic                           pkt_ready;
  logic                           pkt_done;
  logic                           tx_busy;

  modport master (output pkt_valid, pkt_data, input pkt_ready, pkt_done, tx_busy);
  modport slave  (input pkt_valid, pkt_data, output pkt_ready, pkt_done, tx_busy);
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_frame : single-frame UART serialiser, chains frames gap-free |
// | Optional parity bit with macro UART_TX_PARITY_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 tick,
  input  wire logic                 valid,
  input  wire logic [DATA_BITS-1:0] word,
  output logic                      tx,
  output logic                      frame_done
);

  localparam int                 c_cnt_w    = $clog2(DATA_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_BITS - 1);
  localparam logic [c_cnt_w-1:0] c_stop_cnt = c_cnt_w'(STOP_BITS);

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [c_cnt_w-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_tx, w_tx_nxt;

`ifdef UART_TX_PARITY_EN
  logic r_par, w_par_nxt;
  logic w_word_par;
  // Parity is taken from the word as loaded, before any shifting.
  assign w_word_par = (^word) ^ PARITY_ODD;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    frame_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt     = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx_nxt = UART_IDLE_LEVEL;
        if (valid) begin
          w_shift_nxt   = word;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = START;
`ifdef UART_TX_PARITY_EN
          w_par_nxt     = w_word_par;
`endif
        end
      end
      START: if (tick) begin
        w_tx_nxt      = 1'b0;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = DATA;
      end
      DATA: if (tick) begin
        w_tx_nxt    = r_shift[0];
        w_shift_nxt = r_shift >> 1;
        if (r_bit_cnt == c_last_bit) begin
          w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          w_state_nxt   = PARITY;
`else
          w_state_nxt   = STOP;
`endif
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        w_tx_nxt    = r_par;
        w_state_nxt = STOP;
      end
`endif
      STOP: if (tick) begin
        if (r_bit_cnt == c_stop_cnt) begin
          // Frame ends here; a pending word starts its start bit on this same tick.
          frame_done    = 1'b1;
          w_bit_cnt_nxt = '0;
          if (valid) begin
            w_tx_nxt    = 1'b0;
            w_shift_nxt = word;
            w_state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = w_word_par;
`endif
          end else begin
            w_tx_nxt    = UART_IDLE_LEVEL;
            w_state_nxt = IDLE;
          end
        end else begin
          w_tx_nxt      = UART_IDLE_LEVEL;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign tx = r_tx;

endmodule
`default_nettype wire

// File: rtl/uart_pkt_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkt_tx : multi-word UART packet transmitter, valid/ready input  |
// | Optional parity bit with macro UART_TX_PARITY_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
module uart_pkt_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int NUM_BYTES  = 3,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     baud_tick,
  uart_pkt_tx_if.slave  pkt_if,
  output logic          tx
);

  localparam int                 c_idx_w    = $clog2(NUM_BYTES + 1);
  localparam int                 c_pkt_w    = NUM_BYTES * DATA_BITS;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_BYTES - 1);

  logic [c_pkt_w-1:0]   r_pkt;
  logic [c_idx_w-1:0]   r_byte_idx;
  logic                 r_busy;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_frame_valid;
  logic                 w_frame_done;
  logic [DATA_BITS-1:0] w_word;

  assign pkt_if.pkt_ready = ~rst & ~r_busy;
  assign w_accept         = pkt_if.pkt_valid & pkt_if.pkt_ready;
  assign w_last           = (r_byte_idx == c_last_idx);

  // Word 0 goes straight to the serialiser on acceptance; r_pkt keeps the rest.
  assign w_frame_valid = r_busy ? ~w_last : w_accept;
  assign w_word        = r_busy ? r_pkt[DATA_BITS-1:0] : pkt_if.pkt_data[DATA_BITS-1:0];

  assign pkt_if.pkt_done = r_busy & w_last & w_frame_done;
  assign pkt_if.tx_busy  = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt      <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_pkt      <= pkt_if.pkt_data >> DATA_BITS;
      r_byte_idx <= '0;
      r_busy     <= 1'b1;
    end else if (r_busy && w_frame_done) begin
      if (w_last) begin
        r_byte_idx <= '0;
        r_busy     <= 1'b0;
      end else begin
        r_pkt      <= r_pkt >> DATA_BITS;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
    end
  end

  uart_tx_frame #(
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .tick       (baud_tick),
    .valid      (w_frame_valid),
    .word       (w_word),
    .tx         (tx),
    .frame_done (w_frame_done)
  );

endmodule
`default_nettype wire
